// File: rtl/control_fsm.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB; ALU ops take 4 cycles from handshake.
// Backpressure: instr_ready only in FETCH; MEM holds its enable until mem_ack or MEM_TIMEOUT.
module control_fsm #(
    parameter int INSTR_W     = 8,
    parameter int REG_AW      = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic              instr_ready,
    input  logic              alu_zero,
    input  logic              mem_ack,
    input  logic              err_clr,
    output logic [REG_AW-1:0] reg_addr_0,
    output logic [REG_AW-1:0] reg_addr_1,
    output logic [REG_AW-1:0] reg_addr_w,
    output logic              reg_w_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [1:0]        sel_w_source,
    output logic              pc_en,
    output logic [1:0]        pc_sel,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_JAL  = 4'b1001;
    localparam logic [3:0] OP_LW   = 4'b1010;
    localparam logic [3:0] OP_SW   = 4'b1011;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_BNE  = 4'b1101;
    localparam logic [3:0] OP_LI   = 4'b1111;

    state_t               r_state;
    state_t               w_next;
    logic [INSTR_W-1:0]   r_ir;
    logic [7:0]           r_mem_cnt;
    logic                 r_err;
    logic [3:0]           w_opcode;
    logic [REG_AW-1:0]    w_rd;
    logic [REG_AW-1:0]    w_rs;
    logic                 w_timeout;

    assign w_opcode   = r_ir[INSTR_W-1 -: 4];
    assign w_rd       = r_ir[2*REG_AW-1:REG_AW];
    assign w_rs       = r_ir[REG_AW-1:0];
    assign reg_addr_0 = w_rs;
    assign reg_addr_1 = w_rd;
    assign instr_ready = (r_state == S_FETCH);
    assign busy        = (r_state != S_FETCH);
    assign err         = r_err;

    // Last permitted MEM cycle with no ack; an ack in the same cycle takes priority.
    assign w_timeout = (r_state == S_MEM) && !mem_ack &&
                       (r_mem_cnt == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_mem_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (instr_valid && instr_ready)
                r_ir <= instr;
            if (r_state == S_MEM && w_next == S_MEM)
                r_mem_cnt <= r_mem_cnt + 8'd1;
            else
                r_mem_cnt <= '0;
            if (w_timeout)
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;
        end
    end

    always_comb begin
        case (w_opcode)
            OP_ADD, OP_AND, OP_NOR, OP_SLT, OP_BEQ, OP_BNE: reg_addr_w = '0;
            default:                                        reg_addr_w = w_rd;
        endcase
        case (w_opcode)
            OP_LW:   sel_w_source = 2'd1;
            OP_LI:   sel_w_source = 2'd2;
            default: sel_w_source = 2'd0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        reg_w_en = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = 2'd0;
        case (r_state)
            S_FETCH: begin
                if (instr_valid)
                    w_next = S_DECODE;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                case (w_opcode)
                    OP_J: begin
                        pc_en  = 1'b1;
                        pc_sel = 2'd1;
                        w_next = S_FETCH;
                    end
                    OP_JAL, OP_LW, OP_SW: w_next = S_MEM;
                    OP_BEQ: begin
                        pc_en  = 1'b1;
                        pc_sel = alu_zero ? 2'd2 : 2'd0;
                        w_next = S_FETCH;
                    end
                    OP_BNE: begin
                        pc_en  = 1'b1;
                        pc_sel = alu_zero ? 2'd0 : 2'd2;
                        w_next = S_FETCH;
                    end
                    default: w_next = S_WB;
                endcase
            end
            S_MEM: begin
                mem_r_en = (w_opcode == OP_LW);
                mem_w_en = (w_opcode != OP_LW);
                if (mem_ack) begin
                    if (w_opcode == OP_LW) begin
                        w_next = S_WB;
                    end else begin
                        pc_en  = 1'b1;
                        pc_sel = (w_opcode == OP_JAL) ? 2'd1 : 2'd0;
                        w_next = S_FETCH;
                    end
                end else if (w_timeout) begin
                    pc_en  = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_WB: begin
                reg_w_en = 1'b1;
                pc_en    = 1'b1;
                w_next   = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: default instance plus a 12-bit/4-bit-address instance.
module tb_control_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, alu_zero, mem_ack, err_clr;

    logic       a_valid, a_ready, a_rwe, a_mre, a_mwe, a_pce, a_busy, a_err;
    logic [7:0] a_instr;
    logic [1:0] a_ra0, a_ra1, a_raw, a_sws, a_pcs;

    logic        b_valid, b_ready, b_rwe, b_mre, b_mwe, b_pce, b_busy, b_err;
    logic [11:0] b_instr;
    logic [3:0]  b_ra0, b_ra1, b_raw;
    logic [1:0]  b_sws, b_pcs;

    control_fsm dut_a (
        .clk(clk), .rst_n(rst_n), .instr_valid(a_valid), .instr(a_instr),
        .instr_ready(a_ready), .alu_zero(alu_zero), .mem_ack(mem_ack), .err_clr(err_clr),
        .reg_addr_0(a_ra0), .reg_addr_1(a_ra1), .reg_addr_w(a_raw),
        .reg_w_en(a_rwe), .mem_r_en(a_mre), .mem_w_en(a_mwe), .sel_w_source(a_sws),
        .pc_en(a_pce), .pc_sel(a_pcs), .busy(a_busy), .err(a_err)
    );

    control_fsm #(.INSTR_W(12), .REG_AW(4), .MEM_TIMEOUT(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr_valid(b_valid), .instr(b_instr),
        .instr_ready(b_ready), .alu_zero(alu_zero), .mem_ack(mem_ack), .err_clr(err_clr),
        .reg_addr_0(b_ra0), .reg_addr_1(b_ra1), .reg_addr_w(b_raw),
        .reg_w_en(b_rwe), .mem_r_en(b_mre), .mem_w_en(b_mwe), .sel_w_source(b_sws),
        .pc_en(b_pce), .pc_sel(b_pcs), .busy(b_busy), .err(b_err)
    );

    typedef struct packed {
        logic       rdy, busy, rwe, mre, mwe, pce;
        logic [1:0] pcs, sws;
        logic [3:0] raw, ra1, ra0;
        logic       err;
    } exp_t;

    typedef struct {
        string tag;
        bit    b;
        exp_t  v;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errs   = 0;

    function automatic exp_t E(input logic rdy, busy, rwe, mre, mwe, pce,
                               input logic [1:0] pcs, sws,
                               input logic [3:0] raw, ra1, ra0,
                               input logic err);
        return {rdy, busy, rwe, mre, mwe, pce, pcs, sws, raw, ra1, ra0, err};
    endfunction

    function automatic exp_t obs(input bit b);
        if (b)
            return {b_ready, b_busy, b_rwe, b_mre, b_mwe, b_pce, b_pcs, b_sws,
                    b_raw, b_ra1, b_ra0, b_err};
        return {a_ready, a_busy, a_rwe, a_mre, a_mwe, a_pce, a_pcs, a_sws,
                {2'b00, a_raw}, {2'b00, a_ra1}, {2'b00, a_ra0}, a_err};
    endfunction

    // Inputs for this cycle are already applied; queue the expectation, let
    // combinational outputs settle, compare, then move to the next cycle.
    task automatic step(input string tag, input exp_t v, input bit b = 1'b0);
        sb_t  e;
        exp_t o;
        sb_q.push_back('{tag: tag, b: b, v: v});
        #1;
        e = sb_q.pop_front();
        o = obs(e.b);
        n_checks++;
        assert (o === e.v) else begin
            n_errs++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, o, e.v);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] ins, input exp_t f, input exp_t d, input string tag);
        a_instr = ins;
        a_valid = 1'b1;
        step({tag, "_fetch"}, f);
        a_valid = 1'b0;
        step({tag, "_dec"}, d);
    endtask

    // sw (rd=1, rs=2) with no ack for 14 MEM cycles; the 15th cycle applies ack15/clr15.
    task automatic sw_run(input string tag, input logic ack15, input logic clr15,
                          input logic err_in, input logic err_out);
        issue(8'b1011_0110, E(1,0,0,0,0,0,0,0,1,1,2,err_in),
              E(0,1,0,0,0,0,0,0,1,1,2,err_in), tag);
        step({tag, "_exec"}, E(0,1,0,0,0,0,0,0,1,1,2,err_in));
        for (int i = 1; i <= 14; i++)
            step($sformatf("%s_mem%0d", tag, i), E(0,1,0,0,1,0,0,0,1,1,2,err_in));
        mem_ack = ack15;
        err_clr = clr15;
        step({tag, "_mem15"}, E(0,1,0,0,1,1,0,0,1,1,2,err_in));
        mem_ack = 1'b0;
        err_clr = 1'b0;
        step({tag, "_done"}, E(1,0,0,0,0,0,0,0,1,1,2,err_out));
    endtask

    initial begin
        rst_n = 1'b0; alu_zero = 1'b0; mem_ack = 1'b0; err_clr = 1'b0;
        a_valid = 1'b0; a_instr = '0; b_valid = 1'b0; b_instr = '0;
        #2;
        step("reset_a", E(1,0,0,0,0,0,0,0,0,0,0,0));
        step("reset_b", E(1,0,0,0,0,0,0,0,0,0,0,0), 1'b1);
        rst_n = 1'b1;

        // add: rd=3 rs=1, write address forced to 0, WB at t+3
        issue(8'b0001_1101, E(1,0,0,0,0,0,0,0,0,0,0,0), E(0,1,0,0,0,0,0,0,0,3,1,0), "add");
        step("add_exec", E(0,1,0,0,0,0,0,0,0,3,1,0));
        step("add_wb",   E(0,1,1,0,0,1,0,0,0,3,1,0));
        step("add_done", E(1,0,0,0,0,0,0,0,0,3,1,0));

        // lw with ack on the third MEM cycle
        issue(8'b1010_1101, E(1,0,0,0,0,0,0,0,0,3,1,0), E(0,1,0,0,0,0,0,1,3,3,1,0), "lw");
        step("lw_exec", E(0,1,0,0,0,0,0,1,3,3,1,0));
        step("lw_mem1", E(0,1,0,1,0,0,0,1,3,3,1,0));
        step("lw_mem2", E(0,1,0,1,0,0,0,1,3,3,1,0));
        mem_ack = 1'b1;
        step("lw_mem3", E(0,1,0,1,0,0,0,1,3,3,1,0));
        mem_ack = 1'b0;
        step("lw_wb",   E(0,1,1,0,0,1,0,1,3,3,1,0));
        step("lw_done", E(1,0,0,0,0,0,0,1,3,3,1,0));

        // branches
        alu_zero = 1'b1;
        issue(8'b1100_0000, E(1,0,0,0,0,0,0,1,3,3,1,0), E(0,1,0,0,0,0,0,0,0,0,0,0), "beq_z");
        step("beq_z_exec", E(0,1,0,0,0,1,2,0,0,0,0,0));
        step("beq_z_done", E(1,0,0,0,0,0,0,0,0,0,0,0));
        issue(8'b1101_0000, E(1,0,0,0,0,0,0,0,0,0,0,0), E(0,1,0,0,0,0,0,0,0,0,0,0), "bne_z");
        step("bne_z_exec", E(0,1,0,0,0,1,0,0,0,0,0,0));
        step("bne_z_done", E(1,0,0,0,0,0,0,0,0,0,0,0));
        alu_zero = 1'b0;
        issue(8'b1101_0000, E(1,0,0,0,0,0,0,0,0,0,0,0), E(0,1,0,0,0,0,0,0,0,0,0,0), "bne_nz");
        step("bne_nz_exec", E(0,1,0,0,0,1,2,0,0,0,0,0));
        step("bne_nz_done", E(1,0,0,0,0,0,0,0,0,0,0,0));

        // j: rd=1 rs=2
        issue(8'b1000_0110, E(1,0,0,0,0,0,0,0,0,0,0,0), E(0,1,0,0,0,0,0,0,1,1,2,0), "j");
        step("j_exec", E(0,1,0,0,0,1,1,0,1,1,2,0));
        step("j_done", E(1,0,0,0,0,0,0,0,1,1,2,0));

        // timeout, clear, ack-beats-timeout, set-beats-clear
        sw_run("sw_to", 1'b0, 1'b0, 1'b0, 1'b1);
        err_clr = 1'b1;
        step("err_clr_cycle", E(1,0,0,0,0,0,0,0,1,1,2,1));
        err_clr = 1'b0;
        step("err_cleared",   E(1,0,0,0,0,0,0,0,1,1,2,0));
        sw_run("sw_ack15", 1'b1, 1'b0, 1'b0, 1'b0);
        sw_run("sw_to_clr", 1'b0, 1'b1, 1'b0, 1'b1);
        err_clr = 1'b1;
        step("err_clr2_cycle", E(1,0,0,0,0,0,0,0,1,1,2,1));
        err_clr = 1'b0;

        // jal: rd=1 rs=3, ack on first MEM cycle
        issue(8'b1001_0111, E(1,0,0,0,0,0,0,0,1,1,2,0), E(0,1,0,0,0,0,0,0,1,1,3,0), "jal");
        step("jal_exec", E(0,1,0,0,0,0,0,0,1,1,3,0));
        mem_ack = 1'b1;
        step("jal_mem",  E(0,1,0,0,1,1,1,0,1,1,3,0));
        mem_ack = 1'b0;
        step("jal_done", E(1,0,0,0,0,0,0,0,1,1,3,0));

        // reset asserted during jal MEM
        issue(8'b1001_0111, E(1,0,0,0,0,0,0,0,1,1,3,0), E(0,1,0,0,0,0,0,0,1,1,3,0), "jal_rst");
        step("jal_rst_exec", E(0,1,0,0,0,0,0,0,1,1,3,0));
        step("jal_rst_mem1", E(0,1,0,0,1,0,0,0,1,1,3,0));
        rst_n = 1'b0;
        step("rst_mid_mem", E(1,0,0,0,0,0,0,0,0,0,0,0));
        rst_n = 1'b1;
        step("rst_after",   E(1,0,0,0,0,0,0,0,0,0,0,0));
        step("rst_idle",    E(1,0,0,0,0,0,0,0,0,0,0,0));

        // wide instance: li 12'hF5A -> rd=5 rs=A, immediate source, WB at t+3
        b_instr = 12'hF5A;
        b_valid = 1'b1;
        step("li_fetch", E(1,0,0,0,0,0,0,0,0,0,0,0), 1'b1);
        b_valid = 1'b0;
        step("li_dec",   E(0,1,0,0,0,0,0,2,5,5,10,0), 1'b1);
        step("li_exec",  E(0,1,0,0,0,0,0,2,5,5,10,0), 1'b1);
        step("li_wb",    E(0,1,1,0,0,1,0,2,5,5,10,0), 1'b1);
        step("li_done",  E(1,0,0,0,0,0,0,2,5,5,10,0), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
